alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/result width in bits; legal values are 8, 16 and 32.
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port alu_cntl  input  3  operation select produced by the ALU control unit.
REQ-005 SHALL provide ports op_a, op_b  input  WIDTH  operands.
REQ-006 SHALL provide port in_valid  input  1  request presents alu_cntl/op_a/op_b.
REQ-007 SHALL provide port in_ready  output  1  block can accept a request.
REQ-008 SHALL provide port result  output  WIDTH  registered result.
REQ-009 SHALL provide ports zero, carry  output  1  result==0; carry-out (ADD) / borrow (SUB), else 0.
REQ-010 SHALL provide ports out_valid  output  1 and out_ready  input  1  result handshake.
REQ-011 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL decode alu_cntl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SLT, 111 MUL.
REQ-013 SHALL implement FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-014 SHALL assert in_ready only in IDLE; a request is accepted on a rising edge where in_valid && in_ready.
REQ-015 SHALL latch alu_cntl, op_a and op_b at acceptance; later input changes do not affect the operation.
REQ-016 SHALL, for non-MUL ops, compute and register result/zero/carry at the accepting edge and enter DONE (out_valid high 1 cycle after acceptance).
REQ-017 SHALL, for MUL, enter MUL and run an unsigned shift-add multiplier of exactly WIDTH iterations (one per cycle), then enter DONE; out_valid high WIDTH+1 cycles after acceptance.
REQ-018 SHALL make MUL result the low WIDTH bits of op_a*op_b; carry=0.
REQ-019 SHALL compute ADD/SUB modulo 2^WIDTH; carry = bit WIDTH of op_a+op_b for ADD, borrow (op_a<op_b unsigned) for SUB.
REQ-020 SHALL compute SLL as op_a shifted left by op_b[log2(WIDTH)-1:0], zero-fill; higher op_b bits ignored.
REQ-021 SHALL compute SLT as 1 when op_a<op_b signed two's-complement, else 0.
REQ-022 SHALL hold out_valid, result, zero, carry stable in DONE until out_ready is sampled high, then return to IDLE on that edge.
REQ-023 SHALL deassert out_valid in IDLE and MUL; result keeps its last value when not valid.
REQ-024 SHALL not accept a new request in the cycle out_ready completes DONE (in_ready=0 in DONE); next acceptance no earlier than the following edge.
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-026 SHALL compute zero from the final registered result for every op.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, result=0, zero=0, carry=0, out_valid=0, busy=0, multiplier accumulator and counter=0; in_ready=0 while rst_n low.
REQ-028 SHALL abort any in-progress MUL or pending DONE on reset; no result is delivered for it.
REQ-029 SHALL assert in_ready on the first rising edge after rst_n deasserts.

Verification
REQ-030 ADD 0xFFFF+0x0001 (WIDTH=16), out_ready=1 -> out_valid 1 cycle later, result=0x0000, zero=1, carry=1.
REQ-031 SUB 0x0003-0x0005 -> result=0xFFFE, carry=1, zero=0; SLT 0x8000 vs 0x0001 -> result=0x0001.
REQ-032 MUL 0x00FF*0x0101 -> busy for 16 cycles, out_valid at cycle 17, result=0xFFFF, carry=0; op_a/op_b toggled during MUL have no effect.
REQ-033 SLL 0x0001 by op_b=0x0013 -> result=0x0008; out_ready held low 5 cycles -> out_valid and result stable, in_ready=0 throughout.
REQ-034 rst_n pulsed low at MUL iteration 8 -> outputs zero immediately, no out_valid, in_ready=1 one edge after release; next ADD 2+3 -> result=0x0005.
REQ-035 Back-to-back in_valid held high with out_ready=1 -> accepts exactly one request every 2 cycles for non-MUL ops, results in order.

Source files
------------

// File: rtl/alu_exec.sv
// Handshaked single-issue ALU: one-cycle ops finish at the accepting edge,
// MUL runs an iterative shift-add multiplier for WIDTH cycles.
module alu_exec #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       alu_cntl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLL = 3'b101, OP_SLT = 3'b110, OP_MUL = 3'b111
  } op_t;

  state_t           state, state_next;
  op_t              op;
  logic             started;
  logic             accept;
  logic             mul_last;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] acc, acc_next, mcand, mplier;
  logic [SW-1:0]    cnt;

  assign op       = op_t'(alu_cntl);
  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt == SW'(WIDTH - 1));
  assign acc_next = mplier[0] ? acc + mcand : acc;

  always_comb begin
    sum       = {1'b0, op_a} + {1'b0, op_b};
    diff      = {1'b0, op_a} - {1'b0, op_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      // Bit WIDTH of the widened difference is the unsigned borrow.
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLL: alu_res = op_a << op_b[SW-1:0];
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // started keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = started;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // The final multiplier iteration writes straight into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        cnt    <= '0;
      end else begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        carry  <= alu_carry;
      end
    end else if (state == MUL) begin
      if (mul_last) begin
        result <= acc_next;
        zero   <= (acc_next == '0);
        carry  <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt + SW'(1);
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: timeline/arithmetic reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_alu_exec;
  localparam int unsigned W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   alu_cntl = '0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, zero, carry, out_valid, busy;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int accepts = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_cntl(alu_cntl), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result), .zero(zero),
    .carry(carry), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [2:0] op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned r,
                                output bit c);
    longint unsigned full;
    longint sa, sb;
    c = 1'b0;
    case (op)
      3'd0: begin full = a + b; r = full & MASK; c = (full > MASK); end
      3'd1: begin r = (a + (MASK + 1) - b) & MASK; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a << (b % W)) & MASK;
      3'd6: begin
        sa = (a >= (MASK + 1) / 2) ? longint'(a) - longint'(MASK + 1) : longint'(a);
        sb = (b >= (MASK + 1) / 2) ? longint'(b) - longint'(MASK + 1) : longint'(b);
        r = (sa < sb) ? 64'd1 : 64'd0;
      end
      default: r = (a * b) & MASK;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Reference timeline: a result becomes visible 1 cycle (MUL: W cycles) after the
  // acceptance edge and stays until out_ready is seen.
  bit              m_started = 1'b0, m_valid = 1'b0, m_z = 1'b0, m_c = 1'b0, p_c;
  int              m_wait = 0;
  longint unsigned m_res = 0, p_res;

  always @(negedge clk) begin : mon
    logic exp_ready;
    if (!rst_n) begin
      m_started = 1'b0; m_valid = 1'b0; m_wait = 0;
      m_res = 0; m_z = 1'b0; m_c = 1'b0;
    end
    exp_ready = rst_n && m_started && (m_wait == 0) && !m_valid;
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, (m_wait != 0) || m_valid);
    check("out_valid", out_valid, m_valid);
    check("result", result, m_res);
    check("zero", zero, m_z);
    check("carry", carry, m_c);
    if (rst_n) begin
      if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_res = p_res; m_z = (p_res == 0); m_c = p_c;
        end
      end else if (exp_ready && in_valid) begin
        accepts++;
        model(alu_cntl, op_a, op_b, p_res, p_c);
        if (alu_cntl == 3'b111) m_wait = W;
        else begin
          m_valid = 1'b1; m_res = p_res; m_z = (p_res == 0); m_c = p_c;
        end
      end
      m_started = 1'b1;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    alu_cntl = op; op_a = a; op_b = b; in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accept_wait", ok, 1'b1);
    op_a = W'($urandom); op_b = W'($urandom); alu_cntl = 3'($urandom);
  endtask

  task automatic await_result(input string name, input logic [W-1:0] er, input bit ez,
                              input bit ec, input int elat);
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk); lat++; got = out_valid;
      @(posedge clk); #1;
      if (!got) begin op_a = W'($urandom); op_b = W'($urandom); end
    end
    check({name, "_latency"}, lat, elat);
    check({name, "_result"}, result, er);
    check({name, "_zero"}, zero, ez);
    check({name, "_carry"}, carry, ec);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); check("ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1; check("ready_after_edge", in_ready, 1'b1);

    send(3'd0, 16'hFFFF, 16'h0001); await_result("add_wrap", 16'h0000, 1'b1, 1'b1, 1);
    send(3'd1, 16'h0003, 16'h0005); await_result("sub_borrow", 16'hFFFE, 1'b0, 1'b1, 1);
    send(3'd6, 16'h8000, 16'h0001); await_result("slt_neg", 16'h0001, 1'b0, 1'b0, 1);
    send(3'd7, 16'h00FF, 16'h0101); await_result("mul", 16'hFFFF, 1'b0, 1'b0, 17);

    out_ready = 1'b0;
    send(3'd5, 16'h0001, 16'h0013); await_result("sll", 16'h0008, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_result", result, 16'h0008);
      check("hold_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("after_hold_valid", out_valid, 1'b0);
    check("after_hold_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    send(3'd7, 16'h1234, 16'h5678);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_result", result, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", in_ready, 1'b0);
    check("abort_zero", zero, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); check("abort_ready_pre", in_ready, 1'b0);
    @(posedge clk); #1; check("abort_ready_post", in_ready, 1'b1);
    send(3'd0, 16'd2, 16'd3); await_result("add_after_rst", 16'h0005, 1'b0, 1'b0, 1);

    begin
      int a0;
      a0 = accepts;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
        alu_cntl = 3'($urandom_range(0, 6)); op_a = rnd(); op_b = rnd();
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("b2b_accepts", accepts - a0, 10);
    end

    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      alu_cntl  = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      op_a      = rnd();
      op_b      = rnd();
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
